// File: rtl/spi_master.sv
// SPI mode-0 initiator with a valid/ready request port and a one-cycle response pulse.
// Define SPI_MASTER_LSB_FIRST_EN for LSB-first shifting; the default build shifts MSB-first.
module spi_master #(
    parameter int DATA_W = 16,
    parameter int DIV_W  = 8,
    parameter int SS_W   = 8,
    localparam int LEN_W = $clog2(DATA_W + 1),
    localparam int SSI_W = $clog2(SS_W)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DIV_W-1:0]  div,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_data,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [SSI_W-1:0]  req_ss,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic              sck,
    output logic [SS_W-1:0]   ss,
    output logic              mosi,
    input  logic              miso
);

    localparam int PW = DIV_W + 1;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LEAD  = 3'd1;
    localparam logic [2:0] HIGH  = 3'd2;
    localparam logic [2:0] LOW   = 3'd3;
    localparam logic [2:0] TRAIL = 3'd4;
    localparam logic [2:0] GAP   = 3'd5;

    logic [2:0]        state_reg;
    logic [PW-1:0]     phase_reg;
    logic [DIV_W-1:0]  div_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  bits_left_reg;
    logic [DATA_W-1:0] tx_reg;
    logic [DATA_W-1:0] rx_reg;
    logic [DATA_W-1:0] resp_data_reg;
    logic              resp_valid_reg;
    logic              req_ready_reg;
    logic              sck_reg;
    logic [SS_W-1:0]   ss_reg;
    logic              mosi_reg;

    logic [LEN_W-1:0]  len_eff;
    logic [SS_W-1:0]   ss_sel_n;
    logic [DATA_W-1:0] len_mask;
    logic              phase_end;
    logic              gap_end;
    logic [DATA_W-1:0] tx_load;
    logic [DATA_W-1:0] tx_shifted;
    logic              tx_load_head;
    logic              tx_shift_head;
    logic [DATA_W-1:0] rx_shifted;
    logic [DATA_W-1:0] rx_aligned;

    always_comb begin
        len_eff = req_len;
        if (req_len == '0 || req_len > LEN_W'(DATA_W)) begin
            len_eff = LEN_W'(DATA_W);
        end
    end

    // An index with no matching line leaves every select high (dummy clocks).
    generate
        for (genvar gi = 0; gi < SS_W; gi++) begin : g_ss_dec
            assign ss_sel_n[gi] = (req_ss != SSI_W'(gi));
        end
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_len_mask
            assign len_mask[gi] = (LEN_W'(gi) < len_reg);
        end
    endgenerate

    assign phase_end = (phase_reg == PW'(div_reg));
    // GAP covers the resp_valid cycle plus a full HALF of ss-high time.
    assign gap_end   = (phase_reg == PW'(div_reg) + PW'(1));

`ifdef SPI_MASTER_LSB_FIRST_EN
    always_comb begin
        tx_load       = req_data;
        tx_load_head  = req_data[0];
        tx_shifted    = tx_reg >> 1;
        tx_shift_head = tx_reg[1];
        rx_shifted    = {miso, rx_reg[DATA_W-1:1]};
        // Samples enter at the top; slide them down so the first lands in bit 0.
        rx_aligned    = rx_reg >> (LEN_W'(DATA_W) - len_reg);
    end
`else
    always_comb begin
        // Left-justify so bit len-1 sits at the MSB and shifts out first.
        tx_load       = req_data << (LEN_W'(DATA_W) - len_eff);
        tx_load_head  = tx_load[DATA_W-1];
        tx_shifted    = tx_reg << 1;
        tx_shift_head = tx_reg[DATA_W-2];
        rx_shifted    = {rx_reg[DATA_W-2:0], miso};
        rx_aligned    = rx_reg;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            phase_reg      <= '0;
            div_reg        <= '0;
            len_reg        <= '0;
            bits_left_reg  <= '0;
            tx_reg         <= '0;
            rx_reg         <= '0;
            resp_data_reg  <= '0;
            resp_valid_reg <= 1'b0;
            req_ready_reg  <= 1'b1;
            sck_reg        <= 1'b0;
            ss_reg         <= '1;
            mosi_reg       <= 1'b1;
        end else begin
            resp_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready_reg) begin
                        state_reg     <= LEAD;
                        req_ready_reg <= 1'b0;
                        phase_reg     <= '0;
                        div_reg       <= div;
                        len_reg       <= len_eff;
                        bits_left_reg <= len_eff;
                        tx_reg        <= tx_load;
                        rx_reg        <= '0;
                        ss_reg        <= ss_sel_n;
                        mosi_reg      <= tx_load_head;
                        sck_reg       <= 1'b0;
                    end
                end
                LEAD, LOW: begin
                    if (phase_end) begin
                        phase_reg     <= '0;
                        sck_reg       <= 1'b1;
                        rx_reg        <= rx_shifted;
                        bits_left_reg <= bits_left_reg - LEN_W'(1);
                        state_reg     <= HIGH;
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end
                HIGH: begin
                    if (phase_end) begin
                        phase_reg <= '0;
                        sck_reg   <= 1'b0;
                        if (bits_left_reg != '0) begin
                            tx_reg    <= tx_shifted;
                            mosi_reg  <= tx_shift_head;
                            state_reg <= LOW;
                        end else begin
                            state_reg <= TRAIL;
                        end
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end
                TRAIL: begin
                    if (phase_end) begin
                        phase_reg      <= '0;
                        ss_reg         <= '1;
                        mosi_reg       <= 1'b1;
                        resp_valid_reg <= 1'b1;
                        resp_data_reg  <= rx_aligned & len_mask;
                        state_reg      <= GAP;
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end
                GAP: begin
                    if (gap_end) begin
                        phase_reg     <= '0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= IDLE;
                    end else begin
                        phase_reg <= phase_reg + PW'(1);
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    phase_reg     <= '0;
                    req_ready_reg <= 1'b1;
                    sck_reg       <= 1'b0;
                    ss_reg        <= '1;
                    mosi_reg      <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_reg;
    assign resp_valid = resp_valid_reg;
    assign resp_data  = resp_data_reg;
    assign sck        = sck_reg;
    assign ss         = ss_reg;
    assign mosi       = mosi_reg;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: stimulus pushes expected responses, a monitor pops
// and checks them on every resp_valid. miso comes from loopback, a bitrev slave or a tie-high.
module tb_spi_master;

    logic        clock;
    logic        reset;
    logic [7:0]  div;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_data;
    logic [4:0]  req_len;
    logic [2:0]  req_ss;
    logic        resp_valid;
    logic [15:0] resp_data;
    logic        sck;
    logic [7:0]  ss;
    logic        mosi;
    logic        miso;

    spi_master dut (
        .clock      (clock),
        .reset      (reset),
        .div        (div),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_data   (req_data),
        .req_len    (req_len),
        .req_ss     (req_ss),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .sck        (sck),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    typedef struct {
        logic [15:0] data;
        int          lat;
        logic [7:0]  ssv;
        int          rises;
        logic [15:0] mosi_bits;
        logic [15:0] mask;
        int          acc;
        int          ss_base;
        int          rise_base;
    } exp_t;

    exp_t sb[$];

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int ss_cnt = 0;
    int rise_cnt = 0;
    int last_resp_cyc = 0;
    int mode = 0;  // 0: loopback, 1: bitrev slave on ss[2], 2: miso tied high
    logic [7:0]  ss_last = 8'hFF;
    logic [15:0] mosi_cap = '0;
    logic        sck_q = 1'b0;
    logic [7:0]  br_in = '0;
    logic [7:0]  br_out = '0;
    logic [7:0]  br_cnt = '0;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
    endfunction

    assign miso = (mode == 0) ? mosi : (mode == 1) ? br_out[7] : 1'b1;

    // Bus observers plus an 8-bit mode-0 slave that answers each byte bit-reversed.
    always @(posedge clock) begin
        cyc   <= cyc + 1;
        sck_q <= sck;
        if (ss != 8'hFF) begin
            ss_cnt  <= ss_cnt + 1;
            ss_last <= ss;
        end
        if (sck && !sck_q) begin
            rise_cnt <= rise_cnt + 1;
            mosi_cap <= {mosi_cap[14:0], mosi};
        end
        if (ss[2]) begin
            br_cnt <= '0;
            br_out <= '0;
        end else begin
            if (sck && !sck_q) begin
                br_in  <= {br_in[6:0], mosi};
                br_cnt <= br_cnt + 8'd1;
            end
            if (!sck && sck_q) begin
                if (br_cnt[2:0] == 3'd0) br_out <= rev8(br_in);
                else                     br_out <= {br_out[6:0], 1'b0};
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per resp_valid pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resp_valid) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_resp: got resp_valid with data %h, required none", resp_data);
                end else begin
                    e = sb.pop_front();
                    chk("resp_data", {16'h0, resp_data}, {16'h0, e.data});
                    chk("latency", cyc - e.acc, e.lat);
                    chk("ss_low_cycles", ss_cnt - e.ss_base, e.lat);
                    chk("ss_pattern", {24'h0, ss_last}, {24'h0, e.ssv});
                    chk("sck_rises", rise_cnt - e.rise_base, e.rises);
                    chk("mosi_bits", {16'h0, mosi_cap & e.mask}, {16'h0, e.mosi_bits});
                    chk("ready_in_gap", {31'h0, req_ready}, 32'h0);
                    chk("ss_released", {24'h0, ss}, 32'hFF);
                    last_resp_cyc = cyc;
                    $display("resp: data=%h latency=%0d rises=%0d ss=%h", resp_data,
                             cyc - e.acc, rise_cnt - e.rise_base, ss_last);
                end
            end
        end
    end

    // e_gap >= 0 checks the distance from the previous resp_valid to this accept.
    task automatic issue(input int md, input logic [7:0] dv, input logic [4:0] ln,
                         input logic [15:0] dat, input logic [2:0] sidx,
                         input logic [15:0] e_data, input int e_lat, input logic [7:0] e_ss,
                         input int e_rises, input logic [15:0] e_mosi,
                         input bit push, input bit hold, input int e_gap);
        exp_t e;
        int k;
        @(negedge clock);
        req_valid = 1'b1;
        req_data  = dat;
        req_len   = ln;
        req_ss    = sidx;
        div       = dv;
        k = 0;
        while (!req_ready && k < 1000) begin
            @(negedge clock);
            k++;
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", k);
            req_valid = 1'b0;
            return;
        end
        mode = md;
        @(posedge clock);
        @(negedge clock);
        if (!hold) req_valid = 1'b0;
        div = ~dv;  // must not affect the transfer in flight
        e.data      = e_data;
        e.lat       = e_lat;
        e.ssv       = e_ss;
        e.rises     = e_rises;
        e.mosi_bits = e_mosi;
        e.mask      = (e_rises >= 16) ? 16'hFFFF : 16'((32'd1 << e_rises) - 1);
        e.acc       = cyc;
        e.ss_base   = ss_cnt;
        e.rise_base = rise_cnt;
        if (push) sb.push_back(e);
        if (e_gap >= 0) chk("accept_gap", cyc - last_resp_cyc, e_gap);
        $display("req: data=%h len=%0d ss_idx=%0d div=%0d", dat, ln, sidx, dv);
    endtask

    initial begin
        int k;
        int rb;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_data  = '0;
        req_len   = '0;
        req_ss    = '0;
        div       = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_sck", {31'h0, sck}, 32'h0);
        chk("rst_ss", {24'h0, ss}, 32'hFF);
        chk("rst_mosi", {31'h0, mosi}, 32'h1);
        chk("rst_ready", {31'h0, req_ready}, 32'h1);
        chk("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        chk("rst_resp_data", {16'h0, resp_data}, 32'h0);
        reset = 1'b0;

        // Loopback, div=0, 16 bits: HALF=1, latency 1*(2*16+1)=33.
        issue(0, 8'd0, 5'd16, 16'hA5C3, 3'd0, 16'hA5C3, 33, 8'hFE, 16, 16'hA5C3, 1, 0, -1);
        // Bitrev slave on ss[2], div=3: first byte returns 00, second returns rev(01)=80.
        issue(1, 8'd3, 5'd16, 16'h0100, 3'd2, 16'h0080, 132, 8'hFB, 16, 16'h0100, 1, 0, -1);
        // len=1, div=1, miso high: HALF=2, latency 2*3=6.
        issue(2, 8'd1, 5'd1, 16'h0001, 3'd5, 16'h0001, 6, 8'hDF, 1, 16'h0001, 1, 0, -1);
        // len=3, miso high: upper result bits must be zero.
        issue(2, 8'd1, 5'd3, 16'hFFFD, 3'd3, 16'h0007, 14, 8'hF7, 3, 16'h0005, 1, 0, -1);
        // len=0 means 16 bits.
        issue(0, 8'd0, 5'd0, 16'h1234, 3'd7, 16'h1234, 33, 8'h7F, 16, 16'h1234, 1, 0, -1);
        // Back-to-back with req_valid held: accept lands in the 2nd clock after resp_valid,
        // which is observed 3 negedges after the resp_valid negedge.
        issue(0, 8'd0, 5'd8, 16'hFF5A, 3'd1, 16'h005A, 17, 8'hFD, 8, 16'h005A, 1, 1, -1);
        issue(0, 8'd0, 5'd8, 16'h00C3, 3'd1, 16'h00C3, 17, 8'hFD, 8, 16'h00C3, 1, 0, 3);

        // Abort with reset after the 5th sck rise; no response may follow.
        issue(0, 8'd1, 5'd8, 16'h003C, 3'd0, 16'h0000, 0, 8'hFE, 0, 16'h0000, 0, 0, -1);
        rb = rise_cnt;
        k = 0;
        while ((rise_cnt - rb) < 5 && k < 200) begin
            @(negedge clock);
            k++;
        end
        chk("abort_rise_seen", rise_cnt - rb, 5);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_ss", {24'h0, ss}, 32'hFF);
        chk("abort_sck", {31'h0, sck}, 32'h0);
        chk("abort_mosi", {31'h0, mosi}, 32'h1);
        chk("abort_ready", {31'h0, req_ready}, 32'h1);
        reset = 1'b0;
        // Normal transfer after the abort, div=2: HALF=3, latency 3*11=33.
        issue(0, 8'd2, 5'd5, 16'h0013, 3'd4, 16'h0013, 33, 8'hEF, 5, 16'h0013, 1, 0, -1);

        k = 0;
        while (sb.size() != 0 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
        end
        repeat (5) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
